// File: rtl/stream_write_combiner.sv
// Write combiner: merges narrow accelerator beats into one AXI-width line buffer
// and evicts the line as a single-beat AXI4 write on a tag change, a full line,
// or an explicit flush.
module stream_write_combiner #(
  parameter int unsigned AXI_ADDR_WIDTH = 64,
  parameter int unsigned AXI_ID_WIDTH   = 16,
  parameter int unsigned AXI_DATA_WIDTH = 512,
  parameter int unsigned CL_DATA_WIDTH  = 64,
  parameter int unsigned CL_ADDR_WIDTH  = 32,
  parameter int unsigned BURST_WIDTH    = 9,
  parameter int unsigned AXI_ID         = 0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  // Request channel
  input  logic [CL_ADDR_WIDTH-1:0]    req_addr,
  input  logic [BURST_WIDTH-1:0]      req_burst_count,
  input  logic                        req_flush,
  input  logic                        req_val,
  output logic                        req_rdy,
  // Accelerator beat channel
  input  logic [CL_DATA_WIDTH-1:0]    s_axi_wdata,
  input  logic [CL_DATA_WIDTH/8-1:0]  s_axi_wstrb,
  input  logic                        s_axi_wvalid,
  output logic                        s_axi_wready,
  // AXI4 write master
  output logic [AXI_ID_WIDTH-1:0]     m_axi_awid,
  output logic [AXI_ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic [7:0]                  m_axi_awlen,
  output logic [2:0]                  m_axi_awsize,
  output logic [1:0]                  m_axi_awburst,
  output logic                        m_axi_awvalid,
  input  logic                        m_axi_awready,
  output logic [AXI_DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [AXI_DATA_WIDTH/8-1:0] m_axi_wstrb,
  output logic                        m_axi_wlast,
  output logic                        m_axi_wvalid,
  input  logic                        m_axi_wready,
  input  logic [1:0]                  m_axi_bresp,
  input  logic                        m_axi_bvalid,
  output logic                        m_axi_bready,
  // Status
  output logic                        err,
  output logic                        busy
);

  localparam int unsigned STRB_W     = CL_DATA_WIDTH / 8;
  localparam int unsigned LINE_BYTES = AXI_DATA_WIDTH / 8;
  localparam int unsigned BPL        = AXI_DATA_WIDTH / CL_DATA_WIDTH;
  localparam int unsigned OFF        = $clog2(LINE_BYTES);
  localparam int unsigned BOFF       = $clog2(STRB_W);
  localparam int unsigned SLOT_W     = (BPL > 1) ? $clog2(BPL) : 1;
  localparam int unsigned TAG_W      = CL_ADDR_WIDTH - OFF;

  typedef enum logic [1:0] {StIdle, StData, StEvict, StResp} state_e;

  state_e                      state_q, state_d;
  logic [CL_ADDR_WIDTH-1:0]    beat_addr_q, beat_addr_d;
  logic [BURST_WIDTH-1:0]      count_q, count_d;
  logic                        flush_q, flush_d;
  logic [AXI_DATA_WIDTH-1:0]   line_q, line_d;
  logic [LINE_BYTES-1:0]       mask_q, mask_d;
  logic [TAG_W-1:0]            tag_q, tag_d;
  logic                        dirty_q, dirty_d;
  logic                        aw_done_q, aw_done_d;
  logic                        w_done_q, w_done_d;
  logic                        err_q, err_d;

  logic [TAG_W-1:0]            beat_tag;
  logic [SLOT_W-1:0]           slot;
  int unsigned                 slot_base;
  logic                        aw_fin, w_fin;

  assign beat_tag = beat_addr_q[CL_ADDR_WIDTH-1:OFF];
  // A line holding a single beat has no slot bits; everything lands in slot 0.
  assign slot      = (BPL > 1) ? beat_addr_q[BOFF +: SLOT_W] : '0;
  assign slot_base = 32'(slot) * STRB_W;

  // Constant AXI fields and line presentation.
  assign m_axi_awid    = AXI_ID_WIDTH'(AXI_ID);
  assign m_axi_awaddr  = AXI_ADDR_WIDTH'({tag_q, {OFF{1'b0}}});
  assign m_axi_awlen   = 8'd0;
  assign m_axi_awsize  = 3'(OFF);
  assign m_axi_awburst = 2'b01;
  assign m_axi_wdata   = line_q;
  assign m_axi_wstrb   = mask_q;
  assign m_axi_wlast   = m_axi_wvalid;
  assign err           = err_q;
  assign busy          = (state_q != StIdle) | dirty_q;

  // State register and line buffer; reset abandons any buffered line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      beat_addr_q <= '0;
      count_q     <= '0;
      flush_q     <= 1'b0;
      line_q      <= '0;
      mask_q      <= '0;
      tag_q       <= '0;
      dirty_q     <= 1'b0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      beat_addr_q <= beat_addr_d;
      count_q     <= count_d;
      flush_q     <= flush_d;
      line_q      <= line_d;
      mask_q      <= mask_d;
      tag_q       <= tag_d;
      dirty_q     <= dirty_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
      err_q       <= err_d;
    end
  end

  // Next-state logic, beat merging and handshake outputs.
  always_comb begin
    state_d       = state_q;
    beat_addr_d   = beat_addr_q;
    count_d       = count_q;
    flush_d       = flush_q;
    line_d        = line_q;
    mask_d        = mask_q;
    tag_d         = tag_q;
    dirty_d       = dirty_q;
    aw_done_d     = aw_done_q;
    w_done_d      = w_done_q;
    err_d         = err_q;
    aw_fin        = 1'b0;
    w_fin         = 1'b0;
    req_rdy       = 1'b0;
    s_axi_wready  = 1'b0;
    m_axi_awvalid = 1'b0;
    m_axi_wvalid  = 1'b0;
    m_axi_bready  = 1'b0;

    unique case (state_q)
      StIdle: begin
        req_rdy = 1'b1;
        if (req_val) begin
          beat_addr_d = req_addr;
          count_d     = req_burst_count;
          flush_d     = req_flush;
          if (req_burst_count != '0) begin
            state_d = StData;
          end else if (req_flush && dirty_q) begin
            state_d = StEvict;
          end
        end
      end

      StData: begin
        if (dirty_q && (beat_tag != tag_q)) begin
          // Beat belongs to another line: write out the current one first.
          state_d = StEvict;
        end else begin
          s_axi_wready = 1'b1;
          if (s_axi_wvalid) begin
            for (int unsigned b = 0; b < STRB_W; b++) begin
              if (s_axi_wstrb[b]) begin
                line_d[(slot_base + b) * 8 +: 8] = s_axi_wdata[b * 8 +: 8];
              end
            end
            mask_d[slot_base +: STRB_W] = mask_q[slot_base +: STRB_W] | s_axi_wstrb;
            if (s_axi_wstrb != '0) begin
              tag_d   = beat_tag;
              dirty_d = 1'b1;
            end
            beat_addr_d = beat_addr_q + CL_ADDR_WIDTH'(STRB_W);
            count_d     = count_q - BURST_WIDTH'(1);
            if (&mask_d) begin
              state_d = StEvict;
            end else if (count_q == BURST_WIDTH'(1)) begin
              state_d = (flush_q && dirty_d) ? StEvict : StIdle;
            end
          end
        end
      end

      StEvict: begin
        m_axi_awvalid = ~aw_done_q;
        m_axi_wvalid  = ~w_done_q;
        aw_fin        = aw_done_q | m_axi_awready;
        w_fin         = w_done_q | m_axi_wready;
        aw_done_d     = aw_fin;
        w_done_d      = w_fin;
        if (aw_fin && w_fin) begin
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = StResp;
        end
      end

      StResp: begin
        m_axi_bready = 1'b1;
        if (m_axi_bvalid) begin
          if (m_axi_bresp != 2'b00) begin
            err_d = 1'b1;
          end
          mask_d  = '0;
          dirty_d = 1'b0;
          state_d = (count_q != '0) ? StData : StIdle;
        end
      end

      default: state_d = StIdle;
    endcase
  end

endmodule
